// File: rtl/pika_gfx_pkg.sv
// Shared graphics constants and the blitter FSM state type.
package pika_gfx_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] TRANSP = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

endpackage

// File: rtl/pika_sprite_blitter_if.sv
// Control, sprite-ROM and frame-buffer write signals of the sprite blitter.
// The master side is the blitter itself; the slave side is its environment.
interface pika_sprite_blitter_if;
  import pika_gfx_pkg::*;

  logic                start;
  logic [7:0]          x0;
  logic [6:0]          y0;
  logic                busy;
  logic                done;
  logic [11:0]         rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    input  start, x0, y0, rom_data,
    output busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output start, x0, y0, rom_data,
    input  busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/pika_sprite_blitter_scan.sv
// Raster walker for one sprite: x fastest, then y, with a running ROM
// address that simply increments so no multiplier is needed.
module pika_scan_counter #(
  parameter int SPR_W = 54,
  parameter int SPR_H = 58,
  localparam int XW = $clog2(SPR_W),
  localparam int YW = $clog2(SPR_H)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] sx,
  output logic [YW-1:0] sy,
  output logic [11:0]   addr,
  output logic          last
);

  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic [11:0]   addr_q, addr_d;

  assign last = (sx_q == XW'(SPR_W - 1)) && (sy_q == YW'(SPR_H - 1));
  assign sx   = sx_q;
  assign sy   = sy_q;
  assign addr = addr_q;

  // Advance one pixel per enabled cycle; the last pixel rewinds to the origin.
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    addr_d = addr_q;
    if (clr) begin
      sx_d   = '0;
      sy_d   = '0;
      addr_d = '0;
    end else if (en) begin
      if (last) begin
        sx_d   = '0;
        sy_d   = '0;
        addr_d = '0;
      end else if (sx_q == XW'(SPR_W - 1)) begin
        sx_d   = '0;
        sy_d   = sy_q + YW'(1);
        addr_d = addr_q + 12'd1;
      end else begin
        sx_d   = sx_q + XW'(1);
        addr_d = addr_q + 12'd1;
      end
    end
  end

  // Counter registers, cleared asynchronously so an abandoned draw leaves nothing behind.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sx_q   <= '0;
      sy_q   <= '0;
      addr_q <= '0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/pika_sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite, reads its ROM and plots every
// opaque pixel that lands on screen. ROM address issue to plot is two cycles.
module pika_sprite_blitter
  import pika_gfx_pkg::*;
#(
  parameter int SPR_W = 54,
  parameter int SPR_H = 58
) (
  input  logic                  clock,
  input  logic                  resetn,
  pika_sprite_blitter_if.master bus
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  blit_state_e state_q, state_d;
  logic        drain_q, drain_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic        scan_clr;
  logic        scan_en;

  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [11:0]   addr;
  logic          last;

  logic          s1_valid_q, s1_valid_d;
  logic [XW-1:0] s1_sx_q, s1_sx_d;
  logic [YW-1:0] s1_sy_q, s1_sy_d;

  logic [8:0]          sum_x;
  logic [7:0]          sum_y;
  logic                on_screen;
  logic [7:0]          vga_x_q, vga_x_d;
  logic [6:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;

  pika_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clr    (scan_clr),
    .en     (scan_en),
    .sx     (sx),
    .sy     (sy),
    .addr   (addr),
    .last   (last)
  );

  assign scan_en = (state_q == SCAN);

  // Next-state logic: accept a start only in IDLE, scan, flush two cycles, pulse done.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    scan_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d     = bus.x0;
          y0_d     = bus.y0;
          scan_clr = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and latched origin registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
    end
  end

  // Pipeline: carry the pixel offsets beside the ROM read, then clip and key-test.
  always_comb begin
    s1_valid_d   = scan_en;
    s1_sx_d      = sx;
    s1_sy_d      = sy;
    sum_x        = {1'b0, x0_q} + 9'(s1_sx_q);
    sum_y        = {1'b0, y0_q} + 8'(s1_sy_q);
    on_screen    = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    if (s1_valid_q) begin
      vga_x_d      = sum_x[7:0];
      vga_y_d      = sum_y[6:0];
      vga_colour_d = bus.rom_data;
      vga_plot_d   = (bus.rom_data != TRANSP) && on_screen;
    end
  end

  // Pipeline and frame-buffer output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_sx_q      <= '0;
      s1_sy_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sx_q      <= s1_sx_d;
      s1_sy_q      <= s1_sy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.rom_addr   = addr;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_pika_sprite_blitter.sv
// Self-checking bench for pika_sprite_blitter. A pixel-level model predicts,
// for every cycle of a draw, whether a plot happens and where, from the
// sprite size, origin and ROM contents alone.
module tb_pika_sprite_blitter;

  localparam int SPR_W  = 54;
  localparam int SPR_H  = 58;
  localparam int NPIX   = SPR_W * SPR_H;
  // Edges counted after the accepting edge: pixel a plots at a+2, done at NPIX+2
  // (the NPIX+3'th cycle counting the cycle in which start was sampled).
  localparam int DONE_E = NPIX + 2;

  logic clock;
  logic resetn;
  logic start;
  logic [7:0] x0;
  logic [6:0] y0;
  int rom_mode;

  pika_sprite_blitter_if bif ();

  assign bif.start = start;
  assign bif.x0    = x0;
  assign bif.y0    = y0;

  pika_sprite_blitter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sprite ROM contents: mode 0 is (sx^sy)%7, mode 1 keys out every even address.
  function automatic logic [2:0] rom_fn(input int mode, input int a);
    int px;
    int py;
    px = a % SPR_W;
    py = a / SPR_W;
    if (mode == 1) begin
      if ((a % 2) == 0) return 3'b111;
      return 3'(a % 7);
    end
    return 3'((px ^ py) % 7);
  endfunction

  // Synchronous-read ROM attached to the blitter.
  always @(posedge clock) bif.rom_data <= rom_fn(rom_mode, int'(bif.rom_addr));

  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Model of the draw timeline: which draw is active and how far along it is.
  logic model_active;
  int   model_e;
  int   model_ox;
  int   model_oy;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      model_active <= 1'b0;
      model_e      <= 0;
    end else if (model_active) begin
      if (model_e == DONE_E) model_active <= 1'b0;
      else model_e <= model_e + 1;
    end else if (start) begin
      model_active <= 1'b1;
      model_e      <= 0;
      model_ox     <= int'(x0);
      model_oy     <= int'(y0);
    end
  end

  // Hand-computed expectations for the current draw.
  int exp_plots;
  int exp_first_e;
  int exp_fx;
  int exp_fy;
  bit exp_odd_only;

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin
    int e, a, px, py, plot_cnt, done_cnt, first_e, first_x, first_y;
    bit exp_q, odd_ok, clip_ok;
    logic [2:0] pc;
    logic [7:0] ex;
    logic [6:0] ey;
    plot_cnt = 0; done_cnt = 0; first_e = -1; first_x = 0; first_y = 0;
    odd_ok = 1'b1; clip_ok = 1'b1;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        checkOutput("reset_outputs",
                    {bif.busy, bif.done, bif.vga_plot, bif.rom_addr, bif.vga_x, bif.vga_y, bif.vga_colour}, 0);
      end else if (!model_active) begin
        checkOutput("idle_status", {bif.busy, bif.done, bif.vga_plot}, 0);
      end else begin
        e = model_e;
        if (e == 0) begin
          plot_cnt = 0; done_cnt = 0; first_e = -1; first_x = 0; first_y = 0;
          odd_ok = 1'b1; clip_ok = 1'b1;
        end
        checkOutput("busy", bif.busy, 1);
        checkOutput("done", bif.done, (e == DONE_E) ? 1 : 0);
        if (e < NPIX) checkOutput("rom_addr", bif.rom_addr, e);
        exp_q = 1'b0; ex = '0; ey = '0; pc = '0;
        if (e >= 2 && e < NPIX + 2) begin
          a  = e - 2;
          px = a % SPR_W;
          py = a / SPR_W;
          pc = rom_fn(rom_mode, a);
          exp_q = (pc != 3'b111) && (model_ox + px < 160) && (model_oy + py < 120);
          ex = 8'(model_ox + px);
          ey = 7'(model_oy + py);
        end
        checkOutput("plot", bif.vga_plot, exp_q);
        if (exp_q) checkOutput("pixel_xyc", {bif.vga_x, bif.vga_y, bif.vga_colour}, {ex, ey, pc});
        if (bif.vga_plot) begin
          plot_cnt++;
          if (first_e < 0) begin
            first_e = e; first_x = int'(bif.vga_x); first_y = int'(bif.vga_y);
          end
          if (((e - 2) % 2) == 0) odd_ok = 1'b0;
          if (bif.vga_x >= 8'd160 || bif.vga_y >= 7'd120) clip_ok = 1'b0;
        end
        if (bif.done) done_cnt++;
        if (e == DONE_E) begin
          checkOutput("plot_count", plot_cnt, exp_plots);
          checkOutput("first_plot_edge", first_e, exp_first_e);
          checkOutput("first_plot_x", first_x, exp_fx);
          checkOutput("first_plot_y", first_y, exp_fy);
          checkOutput("done_count", done_cnt, 1);
          checkOutput("on_screen", clip_ok, 1);
          if (exp_odd_only) checkOutput("odd_addr_only", odd_ok, 1);
        end
      end
    end
  end

  // Launch one draw; called at 2 time units after a rising edge.
  task automatic applyStimulus(input int ox, input int oy, input int mode, input int plots,
                               input int fe, input int fx, input int fy, input bit odd_only);
    exp_plots    = plots;
    exp_first_e  = fe;
    exp_fx       = fx;
    exp_fy       = fy;
    exp_odd_only = odd_only;
    rom_mode     = mode;
    x0           = 8'(ox);
    y0           = 7'(oy);
    start        = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (model_active && n < 5000) begin
      @(posedge clock);
      #1 n++;
    end
    #1;
  endtask

  task automatic waitModelE(input int target);
    int n;
    n = 0;
    while (!(model_active && model_e == target) && n < 5000) begin
      @(posedge clock);
      #1 n++;
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; x0 = '0; y0 = '0; rom_mode = 0;
    exp_plots = 0; exp_first_e = 0; exp_fx = 0; exp_fy = 0; exp_odd_only = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    @(posedge clock);
    #2;

    $display("[TB] basic draw at (10,20)");
    applyStimulus(10, 20, 0, 3132, 2, 10, 20, 1'b0);
    waitIdle();

    $display("[TB] transparency on even addresses");
    applyStimulus(10, 20, 1, 1566, 3, 11, 20, 1'b1);
    waitIdle();

    $display("[TB] clipping at (130,100)");
    applyStimulus(130, 100, 0, 600, 2, 130, 100, 1'b0);
    waitIdle();

    $display("[TB] start while busy");
    applyStimulus(130, 100, 0, 600, 2, 130, 100, 1'b0);
    waitModelE(100);
    x0 = 8'd0; y0 = 7'd0; start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
    waitIdle();

    $display("[TB] reset mid-draw");
    applyStimulus(10, 20, 0, 3132, 2, 10, 20, 1'b0);
    waitModelE(500);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    @(posedge clock);
    #2;
    applyStimulus(5, 5, 0, 3132, 2, 5, 5, 1'b0);
    waitIdle();

    $display("[TB] back-to-back draw");
    applyStimulus(5, 5, 0, 3132, 2, 5, 5, 1'b0);
    waitIdle();

    repeat (3) @(posedge clock);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
